pwm_deadtime_out: RTL and testbench

// - Output stage directly downstream of the PWM core. It consumes pwm_raw and period_end.
// - It produces a gate-drive pair: pwm_hi_o and pwm_lo_o, either complementary or single-ended.
// - Complementary mode inserts programmable dead time between the two outputs; polarity is selectable.
// - Config is shadowed and only changes at PWM period boundaries. A fault input forces both outputs off.

---
 rtl/pwm_deadtime_out.sv | 177 +++++++++++++++++
 tb/tb_pwm_deadtime_out.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_out.sv
`default_nettype none
// ============================================================================
// Module   : pwm_deadtime_out
// Function : PWM gate-drive output stage. It drives complementary or
//            single-ended outputs with dead time and shadowed configuration.
//            Optional macro PWM_FAULT_LATCH_EN makes the fault input sticky.
// Revision : 1.0
// ============================================================================
module pwm_deadtime_out #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pwm_raw,
  input  logic                period_end,
  input  logic [DT_WIDTH-1:0] dead_cycles_i,
  input  logic                invert_i,
  input  logic                complementary_i,
  input  logic                fault_i,
  input  logic                fault_clr_i,
  output logic                pwm_hi_o,
  output logic                pwm_lo_o,
  output logic                dt_active_o,
  output logic                cfg_applied_o,
  output logic                fault_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HI_ON    = 3'd1,
    S_DT_TO_LO = 3'd2,
    S_LO_ON    = 3'd3,
    S_DT_TO_HI = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DT_WIDTH-1:0] r_dt_cnt;
  logic [DT_WIDTH-1:0] w_dt_cnt_nxt;
  logic [DT_WIDTH-1:0] r_dead_s;
  logic                r_invert_s;
  logic                r_comp_s;
  logic                r_pwm_hi;
  logic                r_pwm_lo;
  logic                r_dt_active;
  logic                r_cfg_applied;
  logic                w_fault_eff;
  logic                w_off;
  logic                w_target;
  logic [DT_WIDTH-1:0] w_d;
  logic                w_d_zero;
  logic [DT_WIDTH-1:0] w_dt_load;

  // Shadows follow the inputs while disabled, otherwise only at period ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dead_s      <= '0;
      r_invert_s    <= 1'b0;
      r_comp_s      <= 1'b0;
      r_cfg_applied <= 1'b0;
    end else begin
      if (!enable || period_end) begin
        r_dead_s   <= dead_cycles_i;
        r_invert_s <= invert_i;
        r_comp_s   <= complementary_i;
      end
      r_cfg_applied <= enable && period_end;
    end
  end

`ifdef PWM_FAULT_LATCH_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (fault_i) begin
      r_fault <= 1'b1;
    end else if (fault_clr_i) begin
      r_fault <= 1'b0;
    end
  end

  assign w_fault_eff = r_fault | fault_i;
  assign fault_o     = r_fault;
`else
  logic w_unused_fault_clr;

  assign w_unused_fault_clr = fault_clr_i;
  assign w_fault_eff        = fault_i;
  assign fault_o            = 1'b0;
`endif

  assign w_off     = !enable || w_fault_eff;
  assign w_target  = pwm_raw ^ r_invert_s;
  assign w_d       = r_comp_s ? r_dead_s : '0;
  assign w_d_zero  = (w_d == '0);
  assign w_dt_load = w_d_zero ? '0 : (w_d - DT_WIDTH'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = r_dt_cnt;
    if (w_off) begin
      w_state_nxt  = S_IDLE;
      w_dt_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_dt_cnt_nxt = w_dt_load;
          if (w_target) w_state_nxt = w_d_zero ? S_HI_ON : S_DT_TO_HI;
          else          w_state_nxt = w_d_zero ? S_LO_ON : S_DT_TO_LO;
        end
        S_HI_ON: begin
          if (!w_target) begin
            w_state_nxt  = w_d_zero ? S_LO_ON : S_DT_TO_LO;
            w_dt_cnt_nxt = w_dt_load;
          end
        end
        S_LO_ON: begin
          if (w_target) begin
            w_state_nxt  = w_d_zero ? S_HI_ON : S_DT_TO_HI;
            w_dt_cnt_nxt = w_dt_load;
          end
        end
        // A target that reverts mid dead time returns to the side still safe
        S_DT_TO_HI: begin
          if (!w_target) begin
            w_state_nxt  = S_LO_ON;
            w_dt_cnt_nxt = '0;
          end else if (r_dt_cnt == '0) begin
            w_state_nxt = S_HI_ON;
          end else begin
            w_dt_cnt_nxt = r_dt_cnt - DT_WIDTH'(1);
          end
        end
        S_DT_TO_LO: begin
          if (w_target) begin
            w_state_nxt  = S_HI_ON;
            w_dt_cnt_nxt = '0;
          end else if (r_dt_cnt == '0) begin
            w_state_nxt = S_LO_ON;
          end else begin
            w_dt_cnt_nxt = r_dt_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_dt_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dt_cnt    <= '0;
      r_pwm_hi    <= 1'b0;
      r_pwm_lo    <= 1'b0;
      r_dt_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dt_cnt    <= w_dt_cnt_nxt;
      r_pwm_hi    <= (w_state_nxt == S_HI_ON);
      r_pwm_lo    <= (w_state_nxt == S_LO_ON) && r_comp_s;
      r_dt_active <= (w_state_nxt == S_DT_TO_LO) || (w_state_nxt == S_DT_TO_HI);
    end
  end

  assign pwm_hi_o      = r_pwm_hi;
  assign pwm_lo_o      = r_pwm_lo;
  assign dt_active_o   = r_dt_active;
  assign cfg_applied_o = r_cfg_applied;

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_deadtime_out
// Function : Directed self-checking bench for pwm_deadtime_out.
// Revision : 1.0
// ============================================================================
module tb_pwm_deadtime_out;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       pwm_raw;
  logic       period_end;
  logic [7:0] dead_cycles_i;
  logic       invert_i;
  logic       complementary_i;
  logic       fault_i;
  logic       fault_clr_i;
  logic       pwm_hi_o;
  logic       pwm_lo_o;
  logic       dt_active_o;
  logic       cfg_applied_o;
  logic       fault_o;

  int n_asrt = 0;
  int n_fail = 0;

  pwm_deadtime_out #(.DT_WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pwm_raw         (pwm_raw),
    .period_end      (period_end),
    .dead_cycles_i   (dead_cycles_i),
    .invert_i        (invert_i),
    .complementary_i (complementary_i),
    .fault_i         (fault_i),
    .fault_clr_i     (fault_clr_i),
    .pwm_hi_o        (pwm_hi_o),
    .pwm_lo_o        (pwm_lo_o),
    .dt_active_o     (dt_active_o),
    .cfg_applied_o   (cfg_applied_o),
    .fault_o         (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; pwm_raw = 1'b1; period_end = 1'b1;
    dead_cycles_i = 8'd3; invert_i = 1'b0; complementary_i = 1'b1;
    fault_i = 1'b0; fault_clr_i = 1'b0;
    tick();
    tick();
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL reset_hi: got %b expected 0", pwm_hi_o); end
    n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL reset_lo: got %b expected 0", pwm_lo_o); end
    n_asrt++; if (dt_active_o !== 1'b0) begin n_fail++; $display("FAIL reset_dt: got %b expected 0", dt_active_o); end
    n_asrt++; if (cfg_applied_o !== 1'b0) begin n_fail++; $display("FAIL reset_cfg: got %b expected 0", cfg_applied_o); end
    n_asrt++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
  endtask

  // dead=3, raw steady 0: three dead-time cycles, then lo on the fourth edge
  task automatic test_startup();
    rst_n = 1'b1; enable = 1'b0; period_end = 1'b0; pwm_raw = 1'b0;
    dead_cycles_i = 8'd3; invert_i = 1'b0; complementary_i = 1'b1;
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_asrt++; if (pwm_lo_o !== (i == 4)) begin n_fail++; $display("FAIL startup_lo[%0d]: got %b expected %b", i, pwm_lo_o, (i == 4)); end
      n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL startup_hi[%0d]: got %b expected 0", i, pwm_hi_o); end
      n_asrt++; if (dt_active_o !== (i < 4)) begin n_fail++; $display("FAIL startup_dt[%0d]: got %b expected %b", i, dt_active_o, (i < 4)); end
    end
    n_asrt++; if (cfg_applied_o !== 1'b0) begin n_fail++; $display("FAIL startup_cfg: got %b expected 0", cfg_applied_o); end
  endtask

  task automatic test_transition();
    pwm_raw = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_asrt++; if (pwm_hi_o !== (i == 4)) begin n_fail++; $display("FAIL rise_hi[%0d]: got %b expected %b", i, pwm_hi_o, (i == 4)); end
      n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL rise_lo[%0d]: got %b expected 0", i, pwm_lo_o); end
      n_asrt++; if (dt_active_o !== (i < 4)) begin n_fail++; $display("FAIL rise_dt[%0d]: got %b expected %b", i, dt_active_o, (i < 4)); end
    end
    pwm_raw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_asrt++; if (pwm_lo_o !== (i == 4)) begin n_fail++; $display("FAIL fall_lo[%0d]: got %b expected %b", i, pwm_lo_o, (i == 4)); end
      n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL fall_hi[%0d]: got %b expected 0", i, pwm_hi_o); end
      n_asrt++; if ((pwm_hi_o & pwm_lo_o) !== 1'b0) begin n_fail++; $display("FAIL fall_overlap[%0d]: got hi=%b lo=%b required not both 1", i, pwm_hi_o, pwm_lo_o); end
    end
  endtask

  // dead=5 with a 2-cycle high pulse: pulse is swallowed, lo comes back
  task automatic test_swallow();
    dead_cycles_i = 8'd5; period_end = 1'b1;
    tick();
    period_end = 1'b0;
    n_asrt++; if (cfg_applied_o !== 1'b1) begin n_fail++; $display("FAIL swallow_cfg: got %b expected 1", cfg_applied_o); end
    pwm_raw = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL swallow_lo[%0d]: got %b expected 0", i, pwm_lo_o); end
      n_asrt++; if (dt_active_o !== 1'b1) begin n_fail++; $display("FAIL swallow_dt[%0d]: got %b expected 1", i, dt_active_o); end
      n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL swallow_hi[%0d]: got %b expected 0", i, pwm_hi_o); end
    end
    pwm_raw = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_asrt++; if (pwm_lo_o !== 1'b1) begin n_fail++; $display("FAIL swallow_relo[%0d]: got %b expected 1", i, pwm_lo_o); end
      n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL swallow_rehi[%0d]: got %b expected 0", i, pwm_hi_o); end
    end
  endtask

  task automatic test_shadow();
    dead_cycles_i = 8'd2; period_end = 1'b1;
    tick();
    period_end = 1'b0;
    n_asrt++; if (cfg_applied_o !== 1'b1) begin n_fail++; $display("FAIL shadow_cfg_pulse: got %b expected 1", cfg_applied_o); end
    tick();
    n_asrt++; if (cfg_applied_o !== 1'b0) begin n_fail++; $display("FAIL shadow_cfg_once: got %b expected 0", cfg_applied_o); end
    // Mid-period changes must not take effect yet
    dead_cycles_i = 8'd6; invert_i = 1'b1;
    tick();
    n_asrt++; if (pwm_lo_o !== 1'b1) begin n_fail++; $display("FAIL shadow_hold_lo: got %b expected 1", pwm_lo_o); end
    n_asrt++; if (cfg_applied_o !== 1'b0) begin n_fail++; $display("FAIL shadow_hold_cfg: got %b expected 0", cfg_applied_o); end
    pwm_raw = 1'b1;
    tick();
    tick();
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL shadow_old_dt_hi: got %b expected 0", pwm_hi_o); end
    tick();
    n_asrt++; if (pwm_hi_o !== 1'b1) begin n_fail++; $display("FAIL shadow_old_hi: got %b expected 1", pwm_hi_o); end
    // Period end edge still uses the old invert; new shadows act next cycle
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    n_asrt++; if (pwm_hi_o !== 1'b1) begin n_fail++; $display("FAIL shadow_pe_hi: got %b expected 1", pwm_hi_o); end
    n_asrt++; if (cfg_applied_o !== 1'b1) begin n_fail++; $display("FAIL shadow_pe_cfg: got %b expected 1", cfg_applied_o); end
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL shadow_new_hi[%0d]: got %b expected 0", i, pwm_hi_o); end
      n_asrt++; if (pwm_lo_o !== (i == 7)) begin n_fail++; $display("FAIL shadow_new_lo[%0d]: got %b expected %b", i, pwm_lo_o, (i == 7)); end
      n_asrt++; if (dt_active_o !== (i <= 6)) begin n_fail++; $display("FAIL shadow_new_dt[%0d]: got %b expected %b", i, dt_active_o, (i <= 6)); end
    end
  endtask

  task automatic test_fault();
    enable = 1'b0; dead_cycles_i = 8'd3; complementary_i = 1'b1; invert_i = 1'b0; pwm_raw = 1'b1;
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    n_asrt++; if (pwm_hi_o !== 1'b1) begin n_fail++; $display("FAIL fault_pre_hi: got %b expected 1", pwm_hi_o); end
    fault_i = 1'b1;
    tick();
    fault_i = 1'b0;
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL fault_hi_off: got %b expected 0", pwm_hi_o); end
    n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL fault_lo_off: got %b expected 0", pwm_lo_o); end
`ifdef PWM_FAULT_LATCH_EN
    n_asrt++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL fault_latched: got %b expected 1", fault_o); end
    for (int i = 1; i <= 3; i++) tick();
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL fault_held_hi: got %b expected 0", pwm_hi_o); end
    n_asrt++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL fault_held: got %b expected 1", fault_o); end
    fault_clr_i = 1'b1; fault_i = 1'b1;
    tick();
    n_asrt++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL fault_wins_clr: got %b expected 1", fault_o); end
    fault_i = 1'b0;
    tick();
    fault_clr_i = 1'b0;
    n_asrt++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b expected 0", fault_o); end
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL fault_clr_hi: got %b expected 0", pwm_hi_o); end
`else
    n_asrt++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL fault_tied: got %b expected 0", fault_o); end
`endif
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_asrt++; if (pwm_hi_o !== (i == 4)) begin n_fail++; $display("FAIL fault_resume_hi[%0d]: got %b expected %b", i, pwm_hi_o, (i == 4)); end
      n_asrt++; if (dt_active_o !== (i < 4)) begin n_fail++; $display("FAIL fault_resume_dt[%0d]: got %b expected %b", i, dt_active_o, (i < 4)); end
    end
  endtask

  task automatic test_single_ended();
    logic raw_pat [6];
    raw_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    enable = 1'b0; complementary_i = 1'b0; invert_i = 1'b1; pwm_raw = 1'b0; dead_cycles_i = 8'd3;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pwm_raw = raw_pat[i];
      tick();
      n_asrt++; if (pwm_hi_o !== ~raw_pat[i]) begin n_fail++; $display("FAIL se_hi[%0d]: got %b expected %b", i, pwm_hi_o, ~raw_pat[i]); end
      n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL se_lo[%0d]: got %b expected 0", i, pwm_lo_o); end
      n_asrt++; if (dt_active_o !== 1'b0) begin n_fail++; $display("FAIL se_dt[%0d]: got %b expected 0", i, dt_active_o); end
    end
    // hi is on here; reset must clear it on the next edge
    rst_n = 1'b0;
    tick();
    n_asrt++; if (pwm_hi_o !== 1'b0) begin n_fail++; $display("FAIL midrst_hi: got %b expected 0", pwm_hi_o); end
    n_asrt++; if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL midrst_lo: got %b expected 0", pwm_lo_o); end
    n_asrt++; if (dt_active_o !== 1'b0) begin n_fail++; $display("FAIL midrst_dt: got %b expected 0", dt_active_o); end
    n_asrt++; if (cfg_applied_o !== 1'b0) begin n_fail++; $display("FAIL midrst_cfg: got %b expected 0", cfg_applied_o); end
    n_asrt++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fault: got %b expected 0", fault_o); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_transition();
    test_swallow();
    test_shadow();
    test_fault();
    test_single_ended();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
